lcd_spi_write: RTL and testbench
================================

Name: lcd_spi_write

Overview:
- Byte-level 4-wire SPI serializer for the ST7789-class 240x320 LCD.
- Sits directly downstream of the picture/init command generators. It takes a 9-bit {dc, byte} word and a level write-enable, shifts the byte out MSB-first (SPI mode 0), and returns a one-cycle wr_done per byte.
- Upstream advances its data only on wr_done, so this block also enforces the re-sample gap upstream needs.

Parameters:
- CLK_DIV, 2, SCLK half-period in sys_clk cycles (>=1).
- IDLE_GAP, 2, sys_clk cycles after wr_done before en_write is sampled again (>=2).

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous active-low reset
- en_write  in  1  level request: word on data_in is valid while high
- data_in  in  9  bit8 = dc (0 command, 1 data); bits7:0 = byte
- wr_done  out  1  one-cycle pulse: byte fully shifted out, CS released
- busy  out  1  high from accept through the end of GAP
- lcd_cs_n  out  1  chip select, active low
- lcd_dc  out  1  data/command select to panel
- lcd_sclk  out  1  SPI clock, idles low
- lcd_mosi  out  1  SPI data

Behaviour:
- One clock domain: sys_clk. Reset is asynchronous and active-low on sys_rst_n.
- Reset values: lcd_cs_n=1, lcd_dc=1, lcd_sclk=0, lcd_mosi=0, wr_done=0, busy=0, state=IDLE, all counters 0.
- All outputs are registered.
- FSM (one-hot): IDLE, SETUP, SHIFT, DONE, GAP.
- IDLE:
  - On en_write=1 (accept cycle A): latch data_in into shreg[7:0] and dc_r, then go to SETUP.
  - en_write=0: stay in IDLE.
  - data_in is ignored outside the accept cycle.
- SETUP (CLK_DIV cycles, A+1..A+CLK_DIV): lcd_cs_n=0, lcd_dc=dc_r, lcd_mosi=shreg[7], lcd_sclk=0.
- SHIFT, 8 bits, each 2*CLK_DIV cycles:
  - Bit cell: CLK_DIV cycles with sclk=1 (panel samples on the rising edge), then CLK_DIV cycles with sclk=0.
  - On each falling edge, shreg shifts left and mosi takes the next bit.
  - After bit 0's low phase, go to DONE.
- DONE (1 cycle):
  - wr_done=1, lcd_cs_n=1, sclk=0.
  - Fixed timing: wr_done occurs at cycle A+17*CLK_DIV+1 (CLK_DIV=2 gives A+35).
- GAP (IDLE_GAP cycles):
  - cs high, en_write ignored, then return to IDLE.
  - Purpose: upstream registers its next word 2 cycles after wr_done, and holds en_write high for one extra cycle after its command phase. Sampling inside that window would resend stale data.
- lcd_dc holds its last value outside transfers. mosi holds its last value.
- busy = state != IDLE.
- en_write low mid-transfer: the transfer completes anyway and wr_done still fires. No abort path exists.
- en_write held high continuously: back-to-back bytes, accepted every 17*CLK_DIV+2+IDLE_GAP cycles.
- Bit counter is 3 bits and terminates at 7. The divider counter is sized to CLK_DIV and wraps at CLK_DIV-1.
- Reset asserted mid-transfer: outputs return to reset values immediately, no wr_done is emitted, and the byte is lost.

Decomposition:
- Shared package lcd_pkg:
  - FSM state encodings.
  - DC_CMD=0 and DC_DATA=1.
  - Default CLK_DIV and IDLE_GAP.
  - Panel geometry constants 240/320, shared with the show/init stages.
- One natural sub-module, lcd_spi_tick: free-running half-period counter, enabled only in SETUP/SHIFT. It emits a tick every CLK_DIV cycles and clears on IDLE. The FSM and shifter live in lcd_spi_write.

Test Plan:
- Command byte: en_write=1 with data_in=9'h02C for one cycle.
  - Expect cs_n low for 16 SCLK half-periods plus setup, dc=0.
  - Rising-edge samples 0,0,1,0,1,1,0,0.
  - wr_done at A+35 (CLK_DIV=2), then cs_n=1.
- Data byte: data_in=9'h1BC.
  - Expect dc=1 throughout and samples 1,0,1,1,1,1,0,0.
  - Exactly one wr_done pulse.
- Back-to-back: en_write held high, data changes to 9'h140 two cycles after the first wr_done.
  - The second transfer shifts 0x40, not the old byte.
  - Accept-to-accept spacing is 38 cycles (CLK_DIV=2, IDLE_GAP=2).
- Dropout: en_write deasserted at A+5.
  - The transfer completes, 8 rising edges occur, wr_done fires at A+35.
  - No further accept while en_write=0.
- Reset mid-transfer: sys_rst_n low at A+12.
  - Same cycle: cs_n=1, sclk=0, mosi=0.
  - No wr_done.
  - After release, a new 9'h1FF transfer is correct.
- CLK_DIV=1 sweep: 9'h0A5 produces wr_done at A+18, with the sclk high/low each lasting 1 cycle.

Source files
------------

// File: rtl/lcd_spi_write_pkg.sv
// Shared definitions for the LCD pipeline: SPI writer states, DC encodings,
// default timing parameters and panel geometry.
package lcd_pkg;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_SETUP = 5'b00010,
        ST_SHIFT = 5'b00100,
        ST_DONE  = 5'b01000,
        ST_GAP   = 5'b10000
    } spi_state_t;

    localparam logic DC_CMD  = 1'b0;
    localparam logic DC_DATA = 1'b1;

    localparam int unsigned DEF_CLK_DIV  = 2;
    localparam int unsigned DEF_IDLE_GAP = 2;

    localparam int unsigned LCD_WIDTH  = 240;
    localparam int unsigned LCD_HEIGHT = 320;

endpackage

// File: rtl/lcd_spi_write_if.sv
// Upstream word interface of the SPI writer, with FSM state exposed for checkers.
import lcd_pkg::*;

// Handshake: master holds en_write high with a valid {dc, byte} on data_in;
// the slave samples it only while idle and answers each accepted word with a
// single-cycle wr_done; busy covers accept through the end of the re-sample gap.
interface lcd_spi_write_if;
    logic       en_write;
    logic [8:0] data_in;
    logic       wr_done;
    logic       busy;
    spi_state_t state;

    modport master (output en_write, data_in, input wr_done, busy, state);
    modport slave  (input en_write, data_in, output wr_done, busy, state);
endinterface

// File: rtl/lcd_spi_write_tick.sv
// Half-period tick generator: counts only while enabled, clears otherwise,
// and pulses tick on the last cycle of every CLK_DIV-cycle window.
module lcd_spi_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/lcd_spi_write.sv
// Byte-level SPI mode-0 serializer for the ST7789 panel: one {dc, byte} word
// per accept, MSB first, with a fixed re-sample gap after every wr_done.
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter int unsigned IDLE_GAP = DEF_IDLE_GAP
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    lcd_spi_write_if.slave   up,
    output logic             lcd_cs_n,
    output logic             lcd_dc,
    output logic             lcd_sclk,
    output logic             lcd_mosi
);

    localparam int unsigned GW = $clog2(IDLE_GAP);
    localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

    spi_state_t    state;
    logic [7:0]    shreg;
    logic [2:0]    bit_cnt;
    logic [GW-1:0] gap_cnt;
    logic          wr_done_r;
    logic          busy_r;
    logic          tick_en;
    logic          tick;

    assign tick_en   = (state == ST_SETUP) || (state == ST_SHIFT);
    assign up.state   = state;
    assign up.wr_done = wr_done_r;
    assign up.busy    = busy_r;

    lcd_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (tick_en),
        .tick      (tick)
    );

    // lcd_sclk doubles as the bit-cell phase: high half, then low half.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            wr_done_r <= 1'b0;
            busy_r    <= 1'b0;
            lcd_cs_n  <= 1'b1;
            lcd_dc    <= 1'b1;
            lcd_sclk  <= 1'b0;
            lcd_mosi  <= 1'b0;
        end else begin
            wr_done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (up.en_write) begin
                        shreg    <= up.data_in[7:0];
                        lcd_dc   <= up.data_in[8];
                        lcd_mosi <= up.data_in[7];
                        lcd_cs_n <= 1'b0;
                        lcd_sclk <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    lcd_mosi <= shreg[7];
                    if (tick) begin
                        lcd_sclk <= 1'b1;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (lcd_sclk) begin
                            lcd_sclk <= 1'b0;
                            // The last bit keeps mosi so the line holds its final value.
                            if (bit_cnt != 3'd7) begin
                                shreg    <= {shreg[6:0], 1'b0};
                                lcd_mosi <= shreg[6];
                            end
                        end else if (bit_cnt == 3'd7) begin
                            bit_cnt   <= '0;
                            lcd_cs_n  <= 1'b1;
                            wr_done_r <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            lcd_sclk <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    // Upstream is still presenting the old word here; do not sample.
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        busy_r  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_r   <= 1'b0;
                    lcd_cs_n <= 1'b1;
                    lcd_sclk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_write.sv
// Self-checking bench for lcd_spi_write: table-driven single bytes, then
// back-to-back, dropout, mid-transfer reset and a CLK_DIV=1 instance.
module tb_lcd_spi_write;
  import lcd_pkg::*;

  localparam int CD = 2;
  localparam int GAP = 2;
  localparam int DONE_LAT = 17 * CD + 1;
  localparam int SPACING = 17 * CD + 2 + GAP;

  // clock / reset
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  lcd_spi_write_if up();
  lcd_spi_write_if up1();
  logic cs_n, dc, sclk, mosi;
  logic cs_n1, dc1, sclk1, mosi1;

  lcd_spi_write #(.CLK_DIV(CD), .IDLE_GAP(GAP)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .up(up),
    .lcd_cs_n(cs_n), .lcd_dc(dc), .lcd_sclk(sclk), .lcd_mosi(mosi)
  );

  lcd_spi_write #(.CLK_DIV(1), .IDLE_GAP(2)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .up(up1),
    .lcd_cs_n(cs_n1), .lcd_dc(dc1), .lcd_sclk(sclk1), .lcd_mosi(mosi1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: {dc, byte} and the cycle wr_done must appear in
  logic [8:0] exp_q[$];
  int exp_done_q[$];

  // monitor for the CLK_DIV=2 instance
  logic prev_sclk = 1'b0;
  int nbits = 0;
  logic [7:0] cap = '0;
  int rises = 0;
  int done_cnt = 0;

  always @(negedge sys_clk) begin
    logic [8:0] e;
    int ed;
    if (!sys_rst_n) begin
      prev_sclk = 1'b0;
      nbits = 0;
    end else begin
      if (sclk && !prev_sclk) begin
        cap = {cap[6:0], mosi};
        nbits++;
        rises++;
        check("cs_low_at_rise", 32'(cs_n), 32'(0));
      end
      prev_sclk = sclk;
      if (up.wr_done) begin
        done_cnt++;
        check("cs_high_at_done", 32'(cs_n), 32'(1));
        if (exp_q.size() == 0) begin
          check("unexpected_wr_done", 32'(exp_q.size()), 32'(1));
        end else begin
          e = exp_q.pop_front();
          ed = exp_done_q.pop_front();
          check("byte", 32'(cap), 32'(e[7:0]));
          check("dc", 32'(dc), 32'(e[8]));
          check("bit_count", 32'(nbits), 32'(8));
          check("done_cycle", 32'(cyc), 32'(ed));
        end
        nbits = 0;
      end
    end
  end

  typedef struct {
    logic [8:0] data;
    logic [7:0] exp_bits;
    logic       exp_dc;
  } vec_t;

  vec_t vecs[6];

  // driver: one-cycle request at the current negedge (cycle A)
  task automatic send(input logic [8:0] d, input logic [8:0] exp);
    exp_q.push_back(exp);
    exp_done_q.push_back(cyc + DONE_LAT);
    up.en_write = 1'b1;
    up.data_in = d;
    @(negedge sys_clk);
    up.en_write = 1'b0;
    up.data_in = 9'($urandom_range(0, 511));
  endtask

  initial begin
    int c0, d0, r0, hi, r1, dcyc;
    logic got, pv;
    logic [7:0] cap1;

    vecs[0] = '{9'h02C, 8'b0010_1100, 1'b0};
    vecs[1] = '{9'h1BC, 8'b1011_1100, 1'b1};
    vecs[2] = '{9'h0A5, 8'b1010_0101, 1'b0};
    vecs[3] = '{9'h1FF, 8'b1111_1111, 1'b1};
    vecs[4] = '{9'h100, 8'b0000_0000, 1'b1};
    vecs[5] = '{9'h081, 8'b1000_0001, 1'b0};

    up.en_write = 1'b0;
    up.data_in = '0;
    up1.en_write = 1'b0;
    up1.data_in = '0;

    repeat (3) @(negedge sys_clk);
    check("rst_cs_n", 32'(cs_n), 32'(1));
    check("rst_dc", 32'(dc), 32'(1));
    check("rst_sclk", 32'(sclk), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_wr_done", 32'(up.wr_done), 32'(0));
    check("rst_busy", 32'(up.busy), 32'(0));
    check("rst_state", 32'(up.state), 32'(ST_IDLE));
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // table-driven single bytes
    for (int i = 0; i < 6; i++) begin
      d0 = done_cnt;
      send(vecs[i].data, {vecs[i].exp_dc, vecs[i].exp_bits});
      check("setup_cs_n", 32'(cs_n), 32'(0));
      check("setup_dc", 32'(dc), 32'(vecs[i].exp_dc));
      check("setup_sclk", 32'(sclk), 32'(0));
      check("setup_mosi", 32'(mosi), 32'(vecs[i].exp_bits[7]));
      check("setup_busy", 32'(up.busy), 32'(1));
      repeat (DONE_LAT + GAP + 2) @(negedge sys_clk);
      check("single_done_count", 32'(done_cnt - d0), 32'(1));
      check("single_idle", 32'(up.busy), 32'(0));
    end

    // back-to-back: en_write held, new word appears 2 cycles after wr_done
    d0 = done_cnt;
    c0 = cyc;
    exp_q.push_back(9'h1A5);
    exp_done_q.push_back(c0 + DONE_LAT);
    up.en_write = 1'b1;
    up.data_in = 9'h1A5;
    while (cyc < c0 + DONE_LAT + 2) @(negedge sys_clk);
    up.data_in = 9'h140;
    exp_q.push_back(9'h140);
    exp_done_q.push_back(c0 + SPACING + DONE_LAT);
    check("gap_busy", 32'(up.busy), 32'(1));
    while (cyc < c0 + SPACING + 1) @(negedge sys_clk);
    check("b2b_accepted", 32'(up.state), 32'(ST_SETUP));
    @(negedge sys_clk);
    up.en_write = 1'b0;
    while (cyc < c0 + SPACING + DONE_LAT + GAP + 2) @(negedge sys_clk);
    check("b2b_done_count", 32'(done_cnt - d0), 32'(2));

    // dropout: en_write released at A+5, transfer must still complete
    d0 = done_cnt;
    r0 = rises;
    c0 = cyc;
    exp_q.push_back(9'h0C3);
    exp_done_q.push_back(c0 + DONE_LAT);
    up.en_write = 1'b1;
    up.data_in = 9'h0C3;
    while (cyc < c0 + 5) @(negedge sys_clk);
    up.en_write = 1'b0;
    while (cyc < c0 + DONE_LAT + 20) @(negedge sys_clk);
    check("drop_rises", 32'(rises - r0), 32'(8));
    check("drop_done_count", 32'(done_cnt - d0), 32'(1));
    check("drop_no_accept", 32'(up.busy), 32'(0));

    // reset mid-transfer at A+12 (sclk high, mosi=1 for 0xF0 bit 5)
    d0 = done_cnt;
    c0 = cyc;
    up.en_write = 1'b1;
    up.data_in = 9'h1F0;
    @(negedge sys_clk);
    up.en_write = 1'b0;
    while (cyc < c0 + 12) @(negedge sys_clk);
    check("pre_rst_sclk", 32'(sclk), 32'(1));
    check("pre_rst_mosi", 32'(mosi), 32'(1));
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", 32'(cs_n), 32'(1));
    check("mid_rst_sclk", 32'(sclk), 32'(0));
    check("mid_rst_mosi", 32'(mosi), 32'(0));
    check("mid_rst_busy", 32'(up.busy), 32'(0));
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (40) @(negedge sys_clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'(0));
    send(9'h1FF, 9'h1FF);
    repeat (DONE_LAT + GAP + 2) @(negedge sys_clk);
    check("post_rst_done_count", 32'(done_cnt - d0), 32'(1));

    // CLK_DIV=1 instance
    c0 = cyc;
    up1.en_write = 1'b1;
    up1.data_in = 9'h0A5;
    @(negedge sys_clk);
    up1.en_write = 1'b0;
    hi = 0; r1 = 0; cap1 = '0; pv = 1'b0; got = 1'b0; dcyc = 0;
    for (int k = 0; k < 30; k++) begin
      if (sclk1 && !pv) begin
        cap1 = {cap1[6:0], mosi1};
        r1++;
      end
      if (sclk1) hi++;
      pv = sclk1;
      if (up1.wr_done && !got) begin
        got = 1'b1;
        dcyc = cyc;
      end
      @(negedge sys_clk);
    end
    check("div1_done_seen", 32'(got), 32'(1));
    check("div1_done_cycle", 32'(dcyc - c0), 32'(18));
    check("div1_byte", 32'(cap1), 32'(8'hA5));
    check("div1_rises", 32'(r1), 32'(8));
    check("div1_high_cycles", 32'(hi), 32'(8));

    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
